// File: rtl/rng_sched_pkg.sv
// Shared types and sizing helpers for the rng_test_sched slice.
// Optional feature macro used by the top: RNG_SCHED_TIMEOUT_EN.
package rng_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } sched_state_t;

  localparam int unsigned DEF_SEQ_LEN = 1024;
  localparam int unsigned DEF_TIMEOUT = 4096;

  // Width of a counter that must hold every value 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rng_test_sched_if.sv
// Pin-side bit stream, core broadcast/result and verdict signals of the
// rng_test_sched sequencer. master = environment/cores, slave = scheduler.
interface rng_test_sched_if #(
  parameter int unsigned NUM_TESTS = 2
);
  logic                 start;
  logic                 bit_in;
  logic                 bit_vld;
  logic                 bit_rdy;
  logic                 eps_out;
  logic [NUM_TESTS-1:0] eps_vld_out;
  logic [NUM_TESTS-1:0] test_valid;
  logic [NUM_TESTS-1:0] test_pass;
  logic                 busy;
  logic                 done;
  logic [NUM_TESTS-1:0] pass_mask;
  logic                 pass_all;
  logic                 timeout_err;

  modport master (
    output start, bit_in, bit_vld, test_valid, test_pass,
    input  bit_rdy, eps_out, eps_vld_out, busy, done,
           pass_mask, pass_all, timeout_err
  );

  modport slave (
    input  start, bit_in, bit_vld, test_valid, test_pass,
    output bit_rdy, eps_out, eps_vld_out, busy, done,
           pass_mask, pass_all, timeout_err
  );
endinterface

// File: rtl/rng_result_collector.sv
// Captures the first valid/pass strobe from each test core and flags when
// every core has reported. Later strobes from an already-reported core are
// ignored.
module rng_result_collector #(
  parameter int unsigned NUM_TESTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 capture_en,
  input  logic [NUM_TESTS-1:0] test_valid,
  input  logic [NUM_TESTS-1:0] test_pass,
  output logic [NUM_TESTS-1:0] pass_mask,
  output logic                 all_got
);

  logic [NUM_TESTS-1:0] got_mask;
  logic [NUM_TESTS-1:0] new_cap;

  // Cores reporting for the first time this cycle.
  always_comb begin
    new_cap = '0;
    if (capture_en) new_cap = test_valid & ~got_mask;
  end

  // First capture per core wins; clear on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got_mask  <= '0;
      pass_mask <= '0;
    end else if (clear) begin
      got_mask  <= '0;
      pass_mask <= '0;
    end else begin
      got_mask  <= got_mask | new_cap;
      pass_mask <= (pass_mask & ~new_cap) | (test_pass & new_cap);
    end
  end

  // All-received detect on the registered mask.
  always_comb all_got = &got_mask;

endmodule

// File: rtl/rng_test_sched.sv
// Sequencer that frames SEQ_LEN epsilon bits, broadcasts them to NUM_TESTS
// randomness-test cores and merges their one-shot results into one verdict.
// Optional macro RNG_SCHED_TIMEOUT_EN adds a WAIT-state result timeout.
module rng_test_sched
  import rng_sched_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 2,
  parameter int unsigned SEQ_LEN   = DEF_SEQ_LEN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input logic             clk,
  input logic             rst_n,
  rng_test_sched_if.slave bus
);

  if (SEQ_LEN < 1 || TIMEOUT < 2) begin : g_param_check
    $error("rng_test_sched: SEQ_LEN must be >= 1 and TIMEOUT >= 2");
  end

  localparam int unsigned  BCW      = cnt_width(SEQ_LEN);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(SEQ_LEN - 1);

  sched_state_t   state, next_state;
  logic [BCW-1:0] bit_cnt;
  logic           hs;
  logic           start_acc;
  logic           capture_en;
  logic           all_got;
  logic           timeout_hit;

  // Handshake, start acceptance and status decode from the state register.
  always_comb begin
    bus.bit_rdy = (state == S_STREAM);
    bus.busy    = (state != S_IDLE);
    bus.done    = (state == S_REPORT);
    hs          = bus.bit_vld & (state == S_STREAM);
    start_acc   = bus.start & (state == S_IDLE);
    capture_en  = (state == S_STREAM) | ((state == S_WAIT) & ~timeout_hit);
  end

  rng_result_collector #(
    .NUM_TESTS(NUM_TESTS)
  ) u_collector (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_acc),
    .capture_en (capture_en),
    .test_valid (bus.test_valid),
    .test_pass  (bus.test_pass),
    .pass_mask  (bus.pass_mask),
    .all_got    (all_got)
  );

`ifdef RNG_SCHED_TIMEOUT_EN
  localparam int unsigned    TCW      = cnt_width(TIMEOUT - 1);
  localparam logic [TCW-1:0] WAIT_MAX = TCW'(TIMEOUT - 1);

  logic [TCW-1:0] wait_cnt;
  logic           timeout_q;

  // WAIT-cycle counter, held at zero outside WAIT so it restarts on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Timeout fires on the last allowed WAIT cycle with results still missing.
  always_comb timeout_hit = (state == S_WAIT) && (wait_cnt == WAIT_MAX) && !all_got;

  // Sticky timeout flag, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (start_acc) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end

  // Timeout flag to the output pins.
  always_comb bus.timeout_err = timeout_q;
`else
  // Without the timeout feature WAIT waits indefinitely.
  always_comb begin
    timeout_hit     = 1'b0;
    bus.timeout_err = 1'b0;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (bus.start) next_state = S_STREAM;
      S_STREAM: if (hs && bit_cnt == LAST_BIT) next_state = S_WAIT;
      S_WAIT:   if (all_got || timeout_hit) next_state = S_REPORT;
      S_REPORT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Bit counter; leaves STREAM on reaching SEQ_LEN so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (start_acc) begin
      bit_cnt <= '0;
    end else if (hs) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Registered broadcast of each accepted bit with a one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.eps_out     <= 1'b0;
      bus.eps_vld_out <= '0;
    end else begin
      bus.eps_vld_out <= {NUM_TESTS{hs}};
      if (hs) bus.eps_out <= bus.bit_in;
    end
  end

  // Verdict latched on entry to REPORT so it is valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pass_all <= 1'b0;
    end else if (start_acc) begin
      bus.pass_all <= 1'b0;
    end else if (state == S_WAIT && next_state == S_REPORT) begin
      bus.pass_all <= (&bus.pass_mask) & ~timeout_hit;
    end
  end

endmodule

// File: tb/tb_rng_test_sched.sv
// Directed self-checking bench for rng_test_sched (SEQ_LEN=16, NUM_TESTS=2,
// TIMEOUT=8). Covers both builds of RNG_SCHED_TIMEOUT_EN.
module tb_rng_test_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails = 0;
  int   vld_pulses = 0;
  int   base;
  int   sent;
  logic exp_hs;
  logic exp_bit;

  rng_test_sched_if #(.NUM_TESTS(2)) bus ();

  rng_test_sched #(
    .NUM_TESTS(2),
    .SEQ_LEN  (16),
    .TIMEOUT  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.eps_vld_out == 2'b11) vld_pulses = vld_pulses + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_rdy"}, bus.bit_rdy, 0);
    check({tag, "_eps_out"}, bus.eps_out, 0);
    check({tag, "_eps_vld"}, bus.eps_vld_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_pass_mask"}, bus.pass_mask, 0);
    check({tag, "_pass_all"}, bus.pass_all, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 0; bus.bit_in = 0; bus.bit_vld = 0;
    bus.test_valid = 0; bus.test_pass = 0;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check("idle_busy", bus.busy, 0);

    // Full-rate stream 1010..., with a start pulse while busy that must be ignored.
    bus.start = 1; step(); bus.start = 0;
    check("t1_busy", bus.busy, 1);
    check("t1_bit_rdy", bus.bit_rdy, 1);
    base = vld_pulses;
    for (int i = 0; i < 16; i++) begin
      exp_bit = (i % 2 == 0);
      bus.bit_in = exp_bit; bus.bit_vld = 1; bus.start = (i == 7);
      step();
      check("t1_eps_out", bus.eps_out, exp_bit);
      check("t1_eps_vld", bus.eps_vld_out, 2'b11);
    end
    bus.start = 0; bus.bit_vld = 0;
    check("t1_rdy_low", bus.bit_rdy, 0);
    check("t1_busy_wait", bus.busy, 1);
    step();
    check("t1_vld_drop", bus.eps_vld_out, 0);
    step();
    bus.test_valid = 2'b11; bus.test_pass = 2'b11;
    step();
    bus.test_valid = 0; bus.test_pass = 0;
    check("t1_done_early", bus.done, 0);
    step();
    check("t1_done", bus.done, 1);
    check("t1_pass_mask", bus.pass_mask, 2'b11);
    check("t1_pass_all", bus.pass_all, 1);
    check("t1_timeout_err", bus.timeout_err, 0);
    step();
    check("t1_done_pulse", bus.done, 0);
    check("t1_idle", bus.busy, 0);
    check("t1_hold_all", bus.pass_all, 1);
    check("t1_pulses", vld_pulses - base, 16);

    // Back-pressure with mixed verdict: core0 passes in STREAM, core1 fails in
    // WAIT then strobes pass which must be ignored.
    bus.start = 1; step(); bus.start = 0;
    base = vld_pulses;
    sent = 0;
    for (int k = 0; k < 36; k++) begin
      bus.bit_vld = (k % 2 == 0);
      exp_bit = k[1];
      bus.bit_in = exp_bit;
      bus.test_valid = (k == 4) ? 2'b01 : 2'b00;
      bus.test_pass  = (k == 4) ? 2'b01 : 2'b00;
      exp_hs = bus.bit_vld && (sent < 16);
      step();
      if (exp_hs) begin
        check("t2_eps_vld_hs", bus.eps_vld_out, 2'b11);
        check("t2_eps_out", bus.eps_out, exp_bit);
        sent++;
      end else begin
        check("t2_eps_vld_idle", bus.eps_vld_out, 0);
      end
      check("t2_bit_rdy", bus.bit_rdy, (sent < 16));
    end
    bus.bit_vld = 0; bus.test_valid = 0; bus.test_pass = 0;
    check("t2_pulses", vld_pulses - base, 16);
    bus.test_valid = 2'b10; bus.test_pass = 2'b00;
    step();
    check("t3_done_early", bus.done, 0);
    bus.test_valid = 2'b10; bus.test_pass = 2'b10;
    step();
    bus.test_valid = 0; bus.test_pass = 0;
    check("t3_done", bus.done, 1);
    check("t3_pass_mask", bus.pass_mask, 2'b01);
    check("t3_pass_all", bus.pass_all, 0);
    step();
    check("t3_idle", bus.busy, 0);
    bus.test_valid = 2'b11; bus.test_pass = 2'b11;
    step();
    bus.test_valid = 0; bus.test_pass = 0;
    step();
    check("t3_idle_strobe_mask", bus.pass_mask, 2'b01);
    check("t3_idle_strobe_all", bus.pass_all, 0);
    check("t3_idle_strobe_done", bus.done, 0);

    // Only core0 responds in WAIT.
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 16; i++) begin
      bus.bit_in = 1; bus.bit_vld = 1;
      step();
    end
    bus.bit_vld = 0;
    check("t4_in_wait", bus.bit_rdy, 0);
    bus.test_valid = 2'b01; bus.test_pass = 2'b01;
    step();
    bus.test_valid = 0; bus.test_pass = 0;
`ifdef RNG_SCHED_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      check("t4_no_done", bus.done, 0);
      step();
    end
    check("t4_done", bus.done, 1);
    check("t4_timeout_err", bus.timeout_err, 1);
    check("t4_pass_all", bus.pass_all, 0);
    check("t4_pass_mask", bus.pass_mask, 2'b01);
    step();
    check("t4_idle", bus.busy, 0);
    check("t4_hold_err", bus.timeout_err, 1);
`else
    for (int i = 0; i < 20; i++) begin
      check("t4_no_done", bus.done, 0);
      check("t4_busy", bus.busy, 1);
      step();
    end
    check("t4_timeout_err", bus.timeout_err, 0);
    bus.test_valid = 2'b10; bus.test_pass = 2'b10;
    step();
    bus.test_valid = 0; bus.test_pass = 0;
    check("t4_done_early", bus.done, 0);
    step();
    check("t4_done", bus.done, 1);
    check("t4_pass_mask", bus.pass_mask, 2'b11);
    check("t4_pass_all", bus.pass_all, 1);
    step();
    check("t4_idle", bus.busy, 0);
`endif

    // Reset mid-STREAM after 5 bits, then a full new sequence.
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 5; i++) begin
      bus.bit_in = 1; bus.bit_vld = 1;
      step();
    end
    check("t5_pre_rst_vld", bus.eps_vld_out, 2'b11);
    #1 rst_n = 1'b0;
    #1 check_all_zero("t5_rst");
    bus.bit_vld = 0;
    step();
    rst_n = 1'b1;
    step();
    check("t5_idle", bus.busy, 0);
    bus.start = 1; step(); bus.start = 0;
    base = vld_pulses;
    for (int i = 0; i < 16; i++) begin
      exp_bit = i[0] ^ i[2];
      bus.bit_in = exp_bit; bus.bit_vld = 1;
      step();
      check("t5_eps_out", bus.eps_out, exp_bit);
    end
    check("t5_rdy_low", bus.bit_rdy, 0);
    step();
    check("t5_pulses", vld_pulses - base, 16);
    bus.bit_vld = 0;
    bus.test_valid = 2'b11; bus.test_pass = 2'b01;
    step();
    bus.test_valid = 0; bus.test_pass = 0;
    step();
    check("t5_done", bus.done, 1);
    check("t5_pass_mask", bus.pass_mask, 2'b01);
    check("t5_pass_all", bus.pass_all, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rng_test_sched.md
# rng_test_sched

Sequencer that shares one serial epsilon bit stream among NUM_TESTS randomness-test cores, such as the approximate-entropy and random-excursions engines. It sits between the chip input pins and the test cores. It frames a sequence of SEQ_LEN bits and broadcasts each bit to every core. It then collects each core's one-shot valid/is_random result and drives a single combined verdict, so the cores never drive shared output pins directly.

## Interface
Parameters:
- NUM_TESTS, default 2: number of attached test cores.
- SEQ_LEN, default 1024: bits per test sequence; must be at least 1.
- TIMEOUT, default 4096: cycles allowed in WAIT for results; used only with the timeout feature.

Ports:
- clk, input, 1: the single clock; everything is rising-edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: begin a new sequence; sampled only in IDLE.
- bit_in, input, 1: epsilon bit from the pins.
- bit_vld, input, 1: bit_in is valid this cycle.
- bit_rdy, output, 1: the scheduler accepts a bit this cycle.
- eps_out, output, 1: registered broadcast bit to all cores.
- eps_vld_out, output, NUM_TESTS: per-core bit strobe.
- test_valid, input, NUM_TESTS: per-core result strobe.
- test_pass, input, NUM_TESTS: per-core is_random; qualified by test_valid.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when the verdict is final.
- pass_mask, output, NUM_TESTS: per-core pass flags.
- pass_all, output, 1: combined verdict.
- timeout_err, output, 1: a result was missing at timeout.

## Operation
- FSM states: IDLE, STREAM, WAIT, REPORT.
- IDLE:
  - bit_rdy=0.
  - When start=1: clear the bit counter, got_mask, pass_mask, timeout_err and pass_all, then go to STREAM.
- STREAM:
  - bit_rdy=1.
  - On each handshake (bit_vld&bit_rdy), register bit_in into eps_out and pulse every eps_vld_out bit for one cycle. Increment the bit counter, which is $clog2(SEQ_LEN+1) bits wide and never wraps.
  - The handshake that brings the count to SEQ_LEN moves the FSM to WAIT. bit_rdy is 0 from the next cycle on.
- Result capture (active in STREAM and WAIT):
  - When test_valid[i]=1 and got_mask[i]=0, set got_mask[i] and load pass_mask[i]=test_pass[i].
  - The first capture for a core wins. Later strobes from the same core are ignored.
- WAIT:
  - Go to REPORT when got_mask is all ones. This includes the case where the last strobe arrives in the same cycle as the capture.
  - If all results were already captured during STREAM, WAIT lasts exactly one cycle.
- REPORT:
  - done=1 for one cycle.
  - pass_all = &pass_mask & ~timeout_err.
  - Return to IDLE.
  - pass_mask, pass_all and timeout_err hold until the next accepted start.
- A start while busy=1 is ignored.
- A test_valid outside STREAM and WAIT is ignored.
- Reset mid-operation: all state and outputs return to reset values immediately. eps_vld_out drops asynchronously, and no partial verdict is reported.

## Timing
- Reset values: bit_rdy=0, eps_out=0, eps_vld_out=0, busy=0, done=0, pass_mask=0, pass_all=0, timeout_err=0. The FSM resets to IDLE.
- start sampled in cycle N gives busy=1 and bit_rdy=1 in cycle N+1.
- A handshake in cycle N gives eps_out and eps_vld_out in cycle N+1, a fixed latency of 1.
- The last capture in cycle N gives done in cycle N+2 (N+1 in WAIT, N+2 in REPORT). pass_all is valid in the same cycle as done.
- Full-rate streaming (bit_vld held at 1) completes STREAM in exactly SEQ_LEN cycles.

## Configuration
- RNG_SCHED_TIMEOUT_EN defined:
  - A WAIT-cycle counter clears on entry to WAIT.
  - When the counter reaches TIMEOUT-1 with got_mask incomplete, the FSM goes to REPORT, sets timeout_err=1 and forces pass_all=0.
  - Missing cores report pass_mask=0.
- RNG_SCHED_TIMEOUT_EN undefined:
  - No counter is built.
  - WAIT waits indefinitely.
  - timeout_err is tied to 0.

## Structure
- Package rng_sched_pkg holds:
  - the FSM state enum (2 bits);
  - localparam helpers for the counter widths;
  - the default SEQ_LEN and TIMEOUT values.
- Sub-module rng_result_collector holds got_mask/pass_mask capture and the all-received detect, parameterised by NUM_TESTS. The top holds the FSM, the bit counter, the broadcast register and the timeout counter.

## Test plan
- Full-rate stream: SEQ_LEN=16, NUM_TESTS=2, start, 16 bits 1010…, both cores pass 3 cycles after the last bit -> eps_out echoes each bit at +1 cycle, exactly 16 eps_vld_out pulses, done once, pass_mask=2'b11, pass_all=1.
- Back-pressure: bit_vld toggling every other cycle -> bit_rdy drops after the 16th handshake, and no 17th bit is forwarded.
- Mixed verdict: core0 passes in STREAM, core1 fails in WAIT, core1 strobes again with pass=1 -> pass_mask=2'b01, pass_all=0.
- Timeout (macro defined, TIMEOUT=8): only core0 responds -> done at the 9th WAIT-related cycle, timeout_err=1, pass_all=0.
- Start ignored while busy, and reset mid-STREAM after 5 bits -> all outputs are 0 and IDLE; a new start streams a full 16 bits.
